fc3_acc: RTL and testbench
==========================

FC3_ACC -- requirements
Module: fc3_acc

Interface
- REQ-001 SHALL have parameter IDIM, default 1: number of parallel output neurons (lanes).
- REQ-002 SHALL have parameter PWID, default 10: width of each unsigned offset-binary partial product.
- REQ-003 SHALL have parameter ADIM, default 110*32: accumulation depth, in beats per result.
- REQ-004 SHALL have parameter AWID, default $clog2(ADIM)+1+PWID: accumulator and output width, matching the ReLU stage input width.
- REQ-005 SHALL have port clk, input, 1 bit: single clock.
- REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
- REQ-007 SHALL have port clr, input, 1 bit: synchronous abort of the current accumulation.
- REQ-008 SHALL have port in_valid, input, 1 bit: partial-product beat valid.
- REQ-009 SHALL have port in_ready, output, 1 bit: block can accept a beat.
- REQ-010 SHALL have port in_data, input, [PWID-1:0] x IDIM unpacked: one partial product per lane.
- REQ-011 SHALL have port out_valid, output, 1 bit: accumulated result valid.
- REQ-012 SHALL have port out_ready, input, 1 bit: downstream ReLU/dff stage accepts the result.
- REQ-013 SHALL have port out_data, output, [AWID-1:0] x IDIM unpacked: per-lane sum of ADIM beats.

Function
- REQ-014 SHALL implement states IDLE, ACC and DONE.
- REQ-015 SHALL transfer a beat only in a cycle with in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACC and 0 in DONE.
- REQ-016 On each transferred beat, every lane SHALL add zero-extended in_data to its accumulator, and the beat counter SHALL increment.
- REQ-017 A transfer in IDLE SHALL load the accumulator with in_data, set the counter to 1 and move to ACC (or to DONE if ADIM==1).
- REQ-018 On the ADIM-th transfer, the counter SHALL wrap to 0 and the state SHALL go to DONE.
- REQ-019 out_valid SHALL assert exactly 1 cycle after the ADIM-th transfer and hold stable with out_data until out_valid && out_ready.
- REQ-020 On the DONE handshake, the state SHALL go to IDLE and the accumulators SHALL clear; the next beat is accepted no earlier than the following cycle.
- REQ-021 Cycles with in_valid low SHALL leave the accumulator and counter unchanged (bubbles allowed).
- REQ-022 clr SHALL force IDLE, counter 0 and accumulators 0 next cycle, discarding any beat or handshake in the same cycle; clr SHALL take priority over all other events.
- REQ-023 The sum SHALL never overflow given AWID; the maximum ADIM*(2^PWID-1) is representable.
- REQ-024 A zero-valued neuron SHALL correspond to out_data == ADIM*2^PWID/2, consistent with the downstream PZER.

Reset
- REQ-025 rst SHALL set state IDLE, counter 0, all accumulators 0, out_valid 0 and in_ready 1 on the next clock edge.
- REQ-026 rst SHALL take priority over clr and over all handshakes, including mid-accumulation and in DONE.

Configuration
- REQ-027 SHALL support macro FC3_ACC_OVF_EN; when defined, SHALL add output ovf, [IDIM-1:0], a sticky per-lane flag.
- REQ-028 With FC3_ACC_OVF_EN, ovf[i] SHALL be set when lane i's sum exceeds PPON (ADIM*2^PWID/2 + 2^PWID/2) at the result, and cleared by rst, clr and the DONE handshake.
- REQ-029 Without FC3_ACC_OVF_EN, the ovf port and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
- REQ-030 A shared package fc3_pkg SHALL hold the state enum type and a function computing zero/PPON/PNON offsets from ADIM and PWID.
- REQ-031 SHALL use one sub-module, fc3_acc_lane: a per-lane accumulator register with load/add/clear, instantiated IDIM times via generate.
- REQ-032 Counter width SHALL be $clog2(ADIM+1).

Verification (ADIM=4, PWID=10, IDIM=2)
- REQ-033 Beats lane0 {512,512,512,512} and lane1 {1023,1023,1023,1023} back-to-back SHALL give out_valid 1 cycle after beat 4, with out_data {2048,4092}.
- REQ-034 Same beats with in_valid low for 3 cycles between beats 2 and 3 SHALL give an identical result, with out_valid 1 cycle after the last beat.
- REQ-035 Holding out_ready 0 for 5 cycles in DONE SHALL keep in_ready 0 and out_data stable; in_valid beats offered during DONE SHALL be ignored.
- REQ-036 clr asserted after beat 2, then 4 beats of 1, SHALL give out_data {4,4}.
- REQ-037 rst asserted in ACC and in DONE SHALL give out_valid 0, in_ready 1 and accumulators 0 next cycle.
- REQ-038 With FC3_ACC_OVF_EN, lane0 beats {700,700,700,700} (sum 2800 > PPON 2560) SHALL set ovf[0]=1 and ovf[1]=0 with lane1 beats of 512; both SHALL clear after the handshake.

Source files
------------

// File: rtl/fc3_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fc3_pkg
// Description : Shared types and helpers for the fc3 accumulator slice.
//               - fc3_state_e  : accumulator FSM state encoding
//               - fc3_offs_t   : zero / PPON / PNON offsets of an offset-binary
//                                sum of ADIM beats of PWID-bit products
//               - fc3_offsets(): computes those offsets from ADIM and PWID
// Revision    : 1.0 - initial release
// ============================================================================
package fc3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } fc3_state_e;

  typedef struct packed {
    longint unsigned zero;  // sum representing a zero-valued neuron
    longint unsigned ppon;  // zero + one half-scale product
    longint unsigned pnon;  // zero - one half-scale product
  } fc3_offs_t;

  // Each product carries a bias of 2^PWID/2, so ADIM beats carry ADIM times it.
  function automatic fc3_offs_t fc3_offsets(input int unsigned adim,
                                            input int unsigned pwid);
    fc3_offs_t       o;
    longint unsigned half;
    half   = 64'(1) << (pwid - 1);
    o.zero = 64'(adim) * half;
    o.ppon = o.zero + half;
    o.pnon = o.zero - half;
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc3_acc_lane.sv
`default_nettype none
// ============================================================================
// Module      : fc3_acc_lane
// Description : One output-neuron accumulator register.
//               Priority: rst > clear > load > add > hold.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               clear         - zero the accumulator next cycle
//               load          - acc <= zero-extended in_data
//               add           - acc <= acc + zero-extended in_data
//               in_data       - PWID-bit offset-binary partial product
//               acc_q         - accumulated value (AWID bits)
//               last, ovf_q   - only with FC3_ACC_OVF_EN: final-beat strobe
//                               and sticky "sum above OVF_THR" flag
// Config      : FC3_ACC_OVF_EN adds the overflow flag logic.
// Revision    : 1.0 - initial release
// ============================================================================
module fc3_acc_lane #(
  parameter int PWID = 10,
  parameter int AWID = 16
`ifdef FC3_ACC_OVF_EN
  ,
  parameter logic [AWID-1:0] OVF_THR = '0
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic            add,
  input  logic [PWID-1:0] in_data,
`ifdef FC3_ACC_OVF_EN
  input  logic            last,
  output logic            ovf_q,
`endif
  output logic [AWID-1:0] acc_q
);

  logic [AWID-1:0] acc_d;
  logic [AWID-1:0] in_ext;

  assign in_ext = AWID'(in_data);

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = in_ext;
    end else if (add) begin
      acc_d = acc_q + in_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef FC3_ACC_OVF_EN
  logic ovf_d;

  // Judged on the final sum so the flag lines up with out_valid.
  always_comb begin
    ovf_d = ovf_q;
    if (clear) begin
      ovf_d = 1'b0;
    end else if ((load || add) && last && (acc_d > OVF_THR)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/fc3_acc.sv
`default_nettype none
// ============================================================================
// Module      : fc3_acc
// Description : FC3 layer accumulator. Sums ADIM beats of IDIM parallel
//               offset-binary partial products and presents the per-lane
//               sums with a valid/ready handshake to the ReLU stage.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               clr                  - synchronous abort of the accumulation
//               in_valid/in_ready    - beat handshake
//               in_data[IDIM]        - PWID-bit partial product per lane
//               out_valid/out_ready  - result handshake
//               out_data[IDIM]       - AWID-bit per-lane sum
//               ovf[IDIM-1:0]        - only with FC3_ACC_OVF_EN: sticky
//                                      per-lane "sum above PPON" flags
// Config      : define FC3_ACC_OVF_EN to add the ovf output.
// Revision    : 1.0 - initial release
// ============================================================================
module fc3_acc
  import fc3_pkg::*;
#(
  parameter int IDIM = 1,
  parameter int PWID = 10,
  parameter int ADIM = 110*32,
  parameter int AWID = $clog2(ADIM) + 1 + PWID
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PWID-1:0] in_data  [IDIM],
  output logic            out_valid,
  input  logic            out_ready,
`ifdef FC3_ACC_OVF_EN
  output logic [IDIM-1:0] ovf,
`endif
  output logic [AWID-1:0] out_data [IDIM]
);

  localparam int              CNT_W    = $clog2(ADIM + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADIM - 1);

  fc3_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic xfer;
  logic hs;
  logic last_beat;
  logic lane_clear;
  logic lane_load;
  logic lane_add;

  assign xfer = in_valid && in_ready;
  assign hs   = out_valid && out_ready;

  // The counter sits at 0 in IDLE, so one compare covers both the first
  // beat (ADIM==1) and the ADIM-th beat of a longer accumulation.
  assign last_beat = (cnt_q == CNT_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACC: begin
          if (xfer) begin
            if (last_beat) begin
              state_d = ST_DONE;
              cnt_d   = '0;
            end else begin
              state_d = ST_ACC;
              cnt_d   = cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (hs) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output / datapath control decode
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready   = (state_q != ST_DONE);
    out_valid  = (state_q == ST_DONE);
    // xfer and hs are mutually exclusive (in_ready low in DONE).
    lane_clear = clr || hs;
    lane_load  = xfer && (state_q == ST_IDLE);
    lane_add   = xfer && (state_q == ST_ACC);
  end

`ifdef FC3_ACC_OVF_EN
  localparam fc3_offs_t       OFFS    = fc3_offsets(ADIM, PWID);
  localparam logic [AWID-1:0] OVF_THR = AWID'(OFFS.ppon);
`endif

  // --------------------------------------------------------------------------
  // Per-lane accumulators
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < IDIM; g++) begin : g_lane
    fc3_acc_lane #(
      .PWID    (PWID),
`ifdef FC3_ACC_OVF_EN
      .OVF_THR (OVF_THR),
`endif
      .AWID    (AWID)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clear   (lane_clear),
      .load    (lane_load),
      .add     (lane_add),
      .in_data (in_data[g]),
`ifdef FC3_ACC_OVF_EN
      .last    (last_beat),
      .ovf_q   (ovf[g]),
`endif
      .acc_q   (out_data[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_fc3_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc3_acc
// Description : Directed self-checking bench for fc3_acc with IDIM=2,
//               PWID=10, ADIM=4 (AWID=13). Covers FC3_ACC_OVF_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc3_acc;

  localparam int IDIM = 2;
  localparam int PWID = 10;
  localparam int ADIM = 4;
  localparam int AWID = 13;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr;
  logic            in_valid;
  logic            in_ready;
  logic [PWID-1:0] in_data  [IDIM];
  logic            out_valid;
  logic            out_ready;
  logic [AWID-1:0] out_data [IDIM];
`ifdef FC3_ACC_OVF_EN
  logic [IDIM-1:0] ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fc3_acc #(
    .IDIM (IDIM),
    .PWID (PWID),
    .ADIM (ADIM),
    .AWID (AWID)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FC3_ACC_OVF_EN
    .ovf       (ovf),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input int a, input int b);
    in_valid   = 1'b1;
    in_data[0] = PWID'(a);
    in_data[1] = PWID'(b);
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int a, input int b);
    chk({tag, "_ov"}, 32'(out_valid), 1);
    chk({tag, "_ir"}, 32'(in_ready), 0);
    chk({tag, "_d0"}, 32'(out_data[0]), a);
    chk({tag, "_d1"}, 32'(out_data[1]), b);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_ov"}, 32'(out_valid), 0);
    chk({tag, "_ir"}, 32'(in_ready), 1);
    chk({tag, "_d0"}, 32'(out_data[0]), 0);
    chk({tag, "_d1"}, 32'(out_data[1]), 0);
  endtask

  initial begin
    rst        = 1'b1;
    clr        = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_data[0] = '0;
    in_data[1] = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_cleared("reset");

    // Back-to-back beats: 4*512 = 2048 (zero neuron), 4*1023 = 4092.
    beat(512, 1023);
    beat(512, 1023);
    beat(512, 1023);
    chk("b2b_ov_early", 32'(out_valid), 0);
    chk("b2b_ir_acc", 32'(in_ready), 1);
    beat(512, 1023);
    chk_result("b2b", 2048, 4092);

    // Back-pressure in DONE with beats offered: they must be ignored.
    in_valid   = 1'b1;
    in_data[0] = 10'd7;
    in_data[1] = 10'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_result("hold", 2048, 4092);
    end
    in_valid = 1'b0;
    handshake();
    chk_cleared("hs");

    // Bubbles between beats 2 and 3.
    beat(512, 1023);
    beat(512, 1023);
    tick();
    tick();
    tick();
    chk("bub_acc_d0", 32'(out_data[0]), 1024);
    beat(512, 1023);
    chk("bub_ov_early", 32'(out_valid), 0);
    beat(512, 1023);
    chk_result("bub", 2048, 4092);
    handshake();

    // clr after beat 2, with a beat offered in the clr cycle.
    beat(512, 1023);
    beat(512, 1023);
    clr        = 1'b1;
    in_valid   = 1'b1;
    in_data[0] = 10'd100;
    in_data[1] = 10'd100;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk_cleared("clr");
    for (int i = 0; i < 4; i++) beat(1, 1);
    chk_result("clr_res", 4, 4);
    handshake();

    // rst in ACC.
    beat(512, 1023);
    beat(512, 1023);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cleared("rst_acc");

    // rst in DONE.
    for (int i = 0; i < 4; i++) beat(300, 5);
    chk_result("pre_rst_done", 1200, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cleared("rst_done");

    // Full accumulation after reset starts from a clean counter.
    for (int i = 0; i < 4; i++) beat(0, 1023);
    chk_result("post_rst", 0, 4092);
    handshake();

`ifdef FC3_ACC_OVF_EN
    // 4*700 = 2800 > PPON 2560; 4*512 = 2048 is not.
    chk("ovf_idle", 32'(ovf), 0);
    beat(700, 512);
    beat(700, 512);
    beat(700, 512);
    chk("ovf_early", 32'(ovf), 0);
    beat(700, 512);
    chk_result("ovf_res", 2800, 2048);
    chk("ovf_set", 32'(ovf), 1);
    handshake();
    chk("ovf_clr", 32'(ovf), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
